// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive definitions: receiver state encoding, bit-timing helpers and
// default frame constants common to the receiver and transmitter.
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rxState_e;

    localparam int unsigned DEF_CLKS_PER_BIT = 16;
    localparam int unsigned DEF_DATA_BITS    = 8;
    localparam int unsigned DEF_PARITY_EN    = 0;
    localparam int unsigned DEF_PARITY_ODD   = 0;
    localparam int unsigned DEF_STOP_BITS    = 1;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;

    function automatic int unsigned midPoint(input int unsigned clksPerBit);
        return clksPerBit / 2;
    endfunction

    function automatic int unsigned cntWidth(input int unsigned clksPerBit);
        return (clksPerBit <= 2) ? 1 : $clog2(clksPerBit);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sfifo.sv
// Generic show-ahead synchronous FIFO: head word visible whenever not empty, zero when empty.
module uart_rx_sfifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     wrEn,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     rdEn,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign doPop  = rdEn & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign doPush = wrEn & (~full | doPop);
    assign rdData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge sys_clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with mid-bit majority vote, optional parity, 1/2 stop bits,
// feeding a show-ahead receive FIFO read through a valid/ready handshake.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
    parameter int unsigned PARITY_EN    = DEF_PARITY_EN,
    parameter int unsigned PARITY_ODD   = DEF_PARITY_ODD,
    parameter int unsigned STOP_BITS    = DEF_STOP_BITS,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          uart_dataH,
    output logic [DATA_BITS-1:0]          rx_dataH,
    output logic                          rx_par_errH,
    output logic                          rx_frm_errH,
    output logic                          rx_validH,
    input  logic                          rx_readyH,
    output logic                          overrunH,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_countH
);

    localparam int unsigned CW  = cntWidth(CLKS_PER_BIT);
    localparam int unsigned MID = midPoint(CLKS_PER_BIT);
    localparam int unsigned WW  = DATA_BITS + 2;
    localparam int unsigned BW  = 4;

    localparam logic [CW-1:0] MID_M1   = CW'(MID - 1);
    localparam logic [CW-1:0] MID_C    = CW'(MID);
    localparam logic [CW-1:0] MID_P1   = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);
    localparam logic          ODD       = (PARITY_ODD != 0);
    localparam logic          PAR_ON    = (PARITY_EN != 0);

    logic [1:0]           syncQ;
    logic                 lineSync;
    rxState_e             state;
    logic [CW-1:0]        cnt;
    logic                 sampA;
    logic                 sampB;
    logic                 vote;
    logic                 decision;
    logic                 counting;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bitIdx;
    logic                 stopIdx;
    logic                 parErr;
    logic                 frmErr;
    logic                 frmNext;
    logic                 pushReq;
    logic [WW-1:0]        pushWord;
    logic [WW-1:0]        headWord;
    logic                 fifoFull;
    logic                 fifoEmpty;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            syncQ <= '1;
        end else begin
            syncQ <= {syncQ[0], uart_dataH};
        end
    end

    assign lineSync = syncQ[1];
    assign counting = (state != IDLE) && (state != BRK_WAIT);
    assign decision = (cnt == MID_P1);
    assign vote     = (sampA & sampB) | (sampA & lineSync) | (sampB & lineSync);
    assign frmNext  = frmErr | ~vote;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sampA    <= 1'b1;
            sampB    <= 1'b1;
            shreg    <= '0;
            bitIdx   <= '0;
            stopIdx  <= 1'b0;
            parErr   <= 1'b0;
            frmErr   <= 1'b0;
            pushReq  <= 1'b0;
            pushWord <= '0;
        end else begin
            pushReq <= 1'b0;
            // cnt free-runs through the frame; each state decides once per bit at MID+1.
            if (counting) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                if (cnt == MID_M1) begin
                    sampA <= lineSync;
                end
                if (cnt == MID_C) begin
                    sampB <= lineSync;
                end
            end
            case (state)
                IDLE: begin
                    if (!lineSync) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (decision) begin
                        if (vote) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bitIdx  <= '0;
                            stopIdx <= 1'b0;
                            parErr  <= 1'b0;
                            frmErr  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (decision) begin
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (bitIdx == BIT_LAST) begin
                            state <= PAR_ON ? PARITY : STOP;
                        end else begin
                            bitIdx <= bitIdx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (decision) begin
                        parErr <= ((^shreg) ^ vote) != ODD;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    if (decision) begin
                        frmErr <= frmNext;
                        if (stopIdx == STOP_LAST) begin
                            pushReq  <= 1'b1;
                            pushWord <= {frmNext, parErr, shreg};
                            state    <= vote ? IDLE : BRK_WAIT;
                        end else begin
                            stopIdx <= 1'b1;
                        end
                    end
                end
                BRK_WAIT: begin
                    if (lineSync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Receiver never stalls: a push into a full FIFO with no pop is dropped and flagged.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            overrunH <= 1'b0;
        end else begin
            overrunH <= pushReq & fifoFull & ~rx_readyH;
        end
    end

    uart_rx_sfifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) rxFifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wrEn    (pushReq),
        .wrData  (pushWord),
        .rdEn    (rx_readyH),
        .rdData  (headWord),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .count   (fifo_countH)
    );

    assign {rx_frm_errH, rx_par_errH, rx_dataH} = headWord;
    assign rx_validH = ~fifoEmpty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: 8N1 receiver and even-parity receiver driven with hand-built frames.
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       lineA = 1'b1;
    logic       lineB = 1'b1;
    logic       readyA = 1'b0;
    logic       readyB = 1'b0;
    logic [7:0] dataA, dataB;
    logic       parA, parB, frmA, frmB, validA, validB, ovA, ovB;
    logic [2:0] countA, countB;

    int tests = 0;
    int fails = 0;
    int ovCnt = 0;

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (ovA) ovCnt = ovCnt + 1;
    end

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_EN    (0),
        .PARITY_ODD   (0),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (4)
    ) dutA (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .uart_dataH  (lineA),
        .rx_dataH    (dataA),
        .rx_par_errH (parA),
        .rx_frm_errH (frmA),
        .rx_validH   (validA),
        .rx_readyH   (readyA),
        .overrunH    (ovA),
        .fifo_countH (countA)
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_EN    (1),
        .PARITY_ODD   (0),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (4)
    ) dutB (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .uart_dataH  (lineB),
        .rx_dataH    (dataB),
        .rx_par_errH (parB),
        .rx_frm_errH (frmB),
        .rx_validH   (validB),
        .rx_readyH   (readyB),
        .overrunH    (ovB),
        .fifo_countH (countB)
    );

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       parBit;
        logic       stopVal;
        logic [7:0] expData;
        logic       expPar;
        logic       expFrm;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int selValid(input int sel);
        return (sel == 0) ? int'(validA) : int'(validB);
    endfunction

    function automatic int selCount(input int sel);
        return (sel == 0) ? int'(countA) : int'(countB);
    endfunction

    task automatic setLine(input int sel, input logic v);
        if (sel == 0) lineA = v;
        else          lineB = v;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge sys_clk);
    endtask

    task automatic popOne(input int sel);
        if (sel == 0) readyA = 1'b1;
        else          readyB = 1'b1;
        @(negedge sys_clk);
        readyA = 1'b0;
        readyB = 1'b0;
    endtask

    // Called on a negedge; start bit begins at iteration 0. popAt raises rx_readyH for one cycle.
    task automatic sendFrame(input int sel, input logic [7:0] data, input bit parEn,
                             input logic parBit, input logic stopVal,
                             input int popAt, input bit chkLat);
        logic fb[14];
        int   nb;
        int   lastDec;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1 + i] = data[i];
        nb = 9;
        if (parEn) begin
            fb[nb] = parBit;
            nb = nb + 1;
        end
        fb[nb] = stopVal;
        nb = nb + 1;
        lastDec = 13 + CPB * (nb - 1);
        fb[nb] = 1'b1;
        fb[nb + 1] = 1'b1;
        nb = nb + 2;
        for (int k = 0; k < nb * CPB; k++) begin
            if (chkLat && k == lastDec)     check("latency_pre", selValid(sel), 0);
            if (chkLat && k == lastDec + 1) check("latency_post", selValid(sel), 1);
            setLine(sel, fb[k / CPB]);
            if (sel == 0) readyA = (k == popAt);
            @(negedge sys_clk);
        end
        readyA = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
        vecs[4] = '{0, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[5] = '{1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[6] = '{1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[7] = '{1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[8] = '{1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[9] = '{1, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};

        // Reset state
        idle(3);
        check("rst_data", int'(dataA), 0);
        check("rst_valid", int'(validA), 0);
        check("rst_par", int'(parA), 0);
        check("rst_frm", int'(frmA), 0);
        check("rst_ovr", int'(ovA), 0);
        check("rst_count", int'(countA), 0);
        check("rst_validB", int'(validB), 0);
        sys_rst = 1'b0;
        idle(4);

        // 8N1 0xA5 with latency check, then pop to empty
        sendFrame(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, 1'b1);
        check("a5_data", int'(dataA), 8'hA5);
        check("a5_par", int'(parA), 0);
        check("a5_frm", int'(frmA), 0);
        popOne(0);
        check("a5_pop_count", int'(countA), 0);
        check("a5_pop_valid", int'(validA), 0);

        // False start: 5 low cycles then high
        lineA = 1'b0;
        idle(5);
        lineA = 1'b1;
        idle(3 * CPB);
        check("false_start_count", int'(countA), 0);
        check("false_start_valid", int'(validA), 0);

        // Table-driven frames
        for (int v = 0; v < 10; v++) begin
            sendFrame(vecs[v].sel, vecs[v].data, vecs[v].sel == 1, vecs[v].parBit,
                      vecs[v].stopVal, -1, 1'b0);
            check($sformatf("vec%0d_valid", v), selValid(vecs[v].sel), 1);
            check($sformatf("vec%0d_data", v),
                  (vecs[v].sel == 0) ? int'(dataA) : int'(dataB), int'(vecs[v].expData));
            check($sformatf("vec%0d_par", v),
                  (vecs[v].sel == 0) ? int'(parA) : int'(parB), int'(vecs[v].expPar));
            check($sformatf("vec%0d_frm", v),
                  (vecs[v].sel == 0) ? int'(frmA) : int'(frmB), int'(vecs[v].expFrm));
            popOne(vecs[v].sel);
            check($sformatf("vec%0d_count", v), selCount(vecs[v].sel), 0);
        end

        // Pop on empty is ignored
        readyA = 1'b1;
        idle(3);
        readyA = 1'b0;
        check("empty_pop_count", int'(countA), 0);

        // Break: 20 bit-times low gives exactly one entry
        lineA = 1'b0;
        idle(12 * CPB);
        check("brk_mid_count", int'(countA), 1);
        idle(8 * CPB);
        check("brk_end_count", int'(countA), 1);
        check("brk_data", int'(dataA), 0);
        check("brk_frm", int'(frmA), 1);
        check("brk_par", int'(parA), 0);
        lineA = 1'b1;
        idle(2 * CPB);
        check("brk_high_count", int'(countA), 1);
        popOne(0);
        sendFrame(0, 8'h12, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        check("post_brk_data", int'(dataA), 8'h12);
        check("post_brk_frm", int'(frmA), 0);
        popOne(0);

        // Overrun: five frames, no reads
        begin
            int ov0;
            ov0 = ovCnt;
            for (int f = 1; f <= 5; f++) sendFrame(0, 8'(f), 1'b0, 1'b0, 1'b1, -1, 1'b0);
            check("ovr_pulses", ovCnt - ov0, 1);
            check("ovr_count", int'(countA), 4);
            for (int f = 1; f <= 4; f++) begin
                check($sformatf("ovr_head%0d", f), int'(dataA), f);
                popOne(0);
            end
            check("ovr_drained", int'(countA), 0);
        end

        // Full FIFO with simultaneous pop on the push cycle: no overrun
        begin
            int ov0;
            for (int f = 1; f <= 4; f++) sendFrame(0, 8'(8'h10 + f), 1'b0, 1'b0, 1'b1, -1, 1'b0);
            ov0 = ovCnt;
            sendFrame(0, 8'h15, 1'b0, 1'b0, 1'b1, 157, 1'b0);
            check("full_pop_pulses", ovCnt - ov0, 0);
            check("full_pop_count", int'(countA), 4);
            for (int f = 2; f <= 5; f++) begin
                check($sformatf("full_pop_head%0d", f), int'(dataA), 8'h10 + f);
                popOne(0);
            end
        end

        // Reset during data bit 3, FIFO holding one word
        sendFrame(0, 8'h7E, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        check("pre_rst_count", int'(countA), 1);
        lineA = 1'b0;
        idle(CPB);
        lineA = 1'b1; idle(CPB);
        lineA = 1'b1; idle(CPB);
        lineA = 1'b0; idle(CPB);
        lineA = 1'b0; idle(CPB / 2);
        sys_rst = 1'b1;
        #1;
        check("midrst_data", int'(dataA), 0);
        check("midrst_valid", int'(validA), 0);
        check("midrst_count", int'(countA), 0);
        check("midrst_frm", int'(frmA), 0);
        @(negedge sys_clk);
        lineA = 1'b1;
        idle(2);
        sys_rst = 1'b0;
        idle(2 * CPB);
        check("postrst_count", int'(countA), 0);
        sendFrame(0, 8'hC3, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        check("postrst_data", int'(dataA), 8'hC3);
        check("postrst_frm", int'(frmA), 0);
        check("postrst_final_count", int'(countA), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
